agc_controller: RTL and testbench
=================================

AGC_CONTROLLER -- requirements
Module: agc_controller

Interface
REQ-001 Parameter TARGET_DBFS, default -12: target average RSSI, signed integer dBFS.
REQ-002 Parameter HYST_DB, default 3: half-width of the lock window, unsigned integer dB.
REQ-003 Parameter GAIN_STEP, default 2: gain change per decision, dB.
REQ-004 Parameter GAIN_MIN, default 0, and GAIN_MAX, default 60: gain clamp limits, dB.
REQ-005 Parameter GAIN_INIT, default 30: gain after reset, dB.
REQ-006 Parameter SETTLE_SAMPLES, default 4: valid samples discarded after each gain change (range 1..255).
REQ-007 Parameter AVG_LOG2, default 3: the average covers 2^AVG_LOG2 samples (range 0..4).
REQ-008 clk  input  1  the single system clock; all logic is on its rising edge.
REQ-009 rst_n  input  1  asynchronous, active-low reset.
REQ-010 enable_i  input  1  level; high runs the AGC loop.
REQ-011 rssi_dBFS_i  input  24  signed Q16.8 RSSI from the power converter.
REQ-012 rssi_valid_i  input  1  qualifies rssi_dBFS_i for one cycle.
REQ-013 gain_o  output  8  unsigned amplifier gain in dB; feeds the converter's amplifier gain input.
REQ-014 gain_changed_o  output  1  one-cycle pulse in the cycle gain_o takes a new value.
REQ-015 locked_o  output  1  high while the last average was inside the window.

Function
REQ-016 The FSM SHALL have exactly four states: IDLE, SETTLE, ACCUM and DECIDE.
REQ-017 IDLE: accumulator and counters are cleared, and gain_o is held; enable_i=1 moves the FSM to SETTLE.
REQ-018 SETTLE: count SETTLE_SAMPLES valid samples without using them, then go to ACCUM; this flushes samples taken at the old gain from the converter pipeline.
REQ-019 ACCUM: sign-extend each valid sample into a 28-bit signed accumulator.
  - After 2^AVG_LOG2 samples, go to DECIDE.
  - If a sample is valid in the cycle ACCUM is entered, it SHALL be accumulated.
REQ-020 DECIDE, one cycle: avg = accumulator arithmetically shifted right by AVG_LOG2, truncated to Q16.8. Compare avg with the window bounds, each shifted left by 8:
  - avg > (TARGET_DBFS+HYST_DB): gain_o decreases by GAIN_STEP, clamped at GAIN_MIN.
  - avg < (TARGET_DBFS-HYST_DB): gain_o increases by GAIN_STEP, clamped at GAIN_MAX.
  - Otherwise gain_o is unchanged.
  - Boundary values equal to a window bound count as in-window.
REQ-021 gain_o SHALL update on the clock edge that leaves DECIDE, and gain_changed_o SHALL be high that same cycle only if the value actually differs.
REQ-022 A clamped request that produces no change SHALL NOT pulse gain_changed_o.
REQ-023 Exit from DECIDE: to SETTLE if gain changed, otherwise to ACCUM.
REQ-024 locked_o SHALL be set at DECIDE exit when avg is in-window and cleared when it is out-of-window. It is also cleared on entering IDLE.
REQ-025 enable_i low in any state SHALL force IDLE on the next edge. A partial accumulation is discarded and gain_o is retained.
REQ-026 rssi_valid_i in IDLE or DECIDE SHALL be ignored.

Reset
REQ-027 rst_n low SHALL asynchronously set the FSM to IDLE, gain_o=GAIN_INIT, gain_changed_o=0, locked_o=0, and zero all counters and the accumulator.
REQ-028 Reset mid-accumulation SHALL discard all samples. After release, the block waits in IDLE for enable_i.

Configuration
REQ-029 Macro AGC_MANUAL_OVERRIDE_EN, when defined, SHALL add inputs manual_en_i (1 bit) and manual_gain_i (8 bits):
  - While manual_en_i=1, gain_o follows manual_gain_i clamped to [GAIN_MIN, GAIN_MAX], registered with one-cycle latency.
  - Each change of gain_o pulses gain_changed_o.
  - The FSM is held in IDLE and locked_o=0.
  - When manual_en_i falls, the loop restarts at SETTLE from the manual gain if enable_i=1.
REQ-030 Without AGC_MANUAL_OVERRIDE_EN, these ports and their logic SHALL be absent, and behaviour is exactly REQ-016..REQ-028.

Structure
REQ-031 Package agc_pkg SHALL hold the state enum type, the RSSI width (24), the accumulator width (28) and the gain width (8).
REQ-032 A single sub-module, agc_averager, SHALL own the accumulator, the sample counter and the shift. Its ports are clear, valid, sample, done and avg. The FSM and gain logic stay in agc_controller.

Verification
REQ-033 Defaults, enable_i=1, feed 12 valid samples of -5.0 dBFS (0xFFFB00) -> 4 discarded, 8 averaged; gain_o 30->28 with a one-cycle gain_changed_o pulse; locked_o=0.
REQ-034 Defaults, continuous -25.0 dBFS -> gain_o 30->32->34 ..., every step preceded by 4 settle samples plus 8 averaged; stops at 60 with no pulse at the clamp.
REQ-035 Defaults, samples of exactly -9.0 and -15.0 dBFS (boundary) -> no gain change; locked_o=1 after the first DECIDE.
REQ-036 enable_i dropped after 5 of 8 ACCUM samples, then restored -> FSM enters IDLE; gain_o held; restart through SETTLE with the average from fresh samples only.
REQ-037 rst_n asserted asynchronously mid-ACCUM with gain_o=40 -> gain_o=30 and locked_o=0 immediately, with no clock edge needed.
REQ-038 With AGC_MANUAL_OVERRIDE_EN: manual_en_i=1, manual_gain_i=70 -> gain_o=60 after one cycle with one pulse; manual_en_i=0 -> SETTLE entered.

Source files
------------

// File: rtl/agc_pkg.sv
// agc_pkg: shared types and widths for the AGC controller slice.
//   agc_state_t : loop FSM states
//   RSSI_W      : width of the Q16.8 RSSI samples
//   ACC_W       : width of the signed sample accumulator
//   GAIN_W      : width of the amplifier gain word (dB)
//   clamp_gain  : saturates an integer gain into [lo, hi]
package agc_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        ACCUM,
        DECIDE
    } agc_state_t;

    localparam int RSSI_W = 24;
    localparam int ACC_W  = 28;
    localparam int GAIN_W = 8;

    function automatic logic [GAIN_W-1:0] clamp_gain(input int g, input int lo, input int hi);
        if (g < lo)      return GAIN_W'(lo);
        else if (g > hi) return GAIN_W'(hi);
        else             return GAIN_W'(g);
    endfunction

endpackage

// File: rtl/agc_averager.sv
// agc_averager: sums 2^AVG_LOG2 valid RSSI samples and presents the mean.
//   clk, rst_n : clock, async active-low reset
//   clear      : synchronous clear of sum and sample count
//   valid      : sample qualifier
//   sample     : signed Q16.8 RSSI
//   done       : high in the cycle the final sample of a block is accepted
//   avg        : sum >>> AVG_LOG2, truncated to Q16.8
module agc_averager
    import agc_pkg::*;
#(
    parameter int AVG_LOG2 = 3
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clear,
    input  logic                     valid,
    input  logic signed [RSSI_W-1:0] sample,
    output logic                     done,
    output logic signed [RSSI_W-1:0] avg
);

    localparam logic [4:0] LAST = 5'((1 << AVG_LOG2) - 1);

    logic signed [ACC_W-1:0] acc;
    logic [4:0]              cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
            cnt <= '0;
        end else if (clear) begin
            acc <= '0;
            cnt <= '0;
        end else if (valid) begin
            acc <= acc + ACC_W'(sample);   // signed cast sign-extends
            cnt <= cnt + 5'd1;
        end
    end

    // Flagged on the accepting cycle so the FSM reaches DECIDE with the full sum.
    assign done = valid && !clear && (cnt == LAST);
    assign avg  = RSSI_W'(acc >>> AVG_LOG2);

endmodule

// File: rtl/agc_controller.sv
// agc_controller: closed-loop AGC. Settles after each gain change, averages
// RSSI, then steps the amplifier gain toward a target window.
//   clk, rst_n     : clock, async active-low reset
//   enable_i       : runs the loop while high
//   rssi_dBFS_i    : signed Q16.8 RSSI, qualified by rssi_valid_i
//   gain_o         : amplifier gain (dB)
//   gain_changed_o : one-cycle pulse when gain_o takes a new value
//   locked_o       : last average fell inside the window
// Optional feature macro AGC_MANUAL_OVERRIDE_EN adds manual_en_i and
// manual_gain_i, which force a clamped gain and park the FSM in IDLE.
module agc_controller
    import agc_pkg::*;
#(
    parameter int TARGET_DBFS    = -12,
    parameter int HYST_DB        = 3,
    parameter int GAIN_STEP      = 2,
    parameter int GAIN_MIN       = 0,
    parameter int GAIN_MAX       = 60,
    parameter int GAIN_INIT      = 30,
    parameter int SETTLE_SAMPLES = 4,
    parameter int AVG_LOG2       = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable_i,
    input  logic [RSSI_W-1:0] rssi_dBFS_i,
    input  logic              rssi_valid_i,
`ifdef AGC_MANUAL_OVERRIDE_EN
    input  logic              manual_en_i,
    input  logic [GAIN_W-1:0] manual_gain_i,
`endif
    output logic [GAIN_W-1:0] gain_o,
    output logic              gain_changed_o,
    output logic              locked_o
);

    localparam logic signed [RSSI_W-1:0] WIN_HI = RSSI_W'((TARGET_DBFS + HYST_DB) * 256);
    localparam logic signed [RSSI_W-1:0] WIN_LO = RSSI_W'((TARGET_DBFS - HYST_DB) * 256);
    localparam logic [7:0]               SETTLE_LAST = 8'(SETTLE_SAMPLES - 1);

    agc_state_t               state_q, state_d;
    logic [7:0]               settle_cnt;
    logic                     avg_done;
    logic signed [RSSI_W-1:0] avg;
    logic                     above, below;
    logic [GAIN_W-1:0]        gain_req;
    logic                     manual_hold;

`ifdef AGC_MANUAL_OVERRIDE_EN
    assign manual_hold = manual_en_i;
`else
    assign manual_hold = 1'b0;
`endif

    agc_averager #(.AVG_LOG2(AVG_LOG2)) u_avg (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (state_q != ACCUM),
        .valid  (rssi_valid_i && (state_q == ACCUM)),
        .sample (rssi_dBFS_i),
        .done   (avg_done),
        .avg    (avg)
    );

    // Window bounds themselves are in-window.
    assign above = (avg > WIN_HI);
    assign below = (avg < WIN_LO);

    always_comb begin
        gain_req = gain_o;
        if (above)
            gain_req = clamp_gain(int'(gain_o) - GAIN_STEP, GAIN_MIN, GAIN_MAX);
        else if (below)
            gain_req = clamp_gain(int'(gain_o) + GAIN_STEP, GAIN_MIN, GAIN_MAX);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (!enable_i || manual_hold) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    state_d = SETTLE;
                SETTLE:  if (rssi_valid_i && settle_cnt == SETTLE_LAST) state_d = ACCUM;
                ACCUM:   if (avg_done) state_d = DECIDE;
                DECIDE:  state_d = (gain_req != gain_o) ? SETTLE : ACCUM;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            settle_cnt <= '0;
        end else if (state_q == SETTLE) begin
            if (rssi_valid_i)
                settle_cnt <= (settle_cnt == SETTLE_LAST) ? 8'd0 : settle_cnt + 8'd1;
        end else begin
            settle_cnt <= '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gain_o         <= GAIN_W'(GAIN_INIT);
            gain_changed_o <= 1'b0;
        end else begin
            gain_changed_o <= 1'b0;
`ifdef AGC_MANUAL_OVERRIDE_EN
            if (manual_hold) begin
                gain_o         <= clamp_gain(int'(manual_gain_i), GAIN_MIN, GAIN_MAX);
                gain_changed_o <= (clamp_gain(int'(manual_gain_i), GAIN_MIN, GAIN_MAX) != gain_o);
            end else
`endif
            if (state_q == DECIDE && enable_i) begin
                gain_o         <= gain_req;
                gain_changed_o <= (gain_req != gain_o);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            locked_o <= 1'b0;
        else if (manual_hold || state_d == IDLE)
            locked_o <= 1'b0;
        else if (state_q == DECIDE)
            locked_o <= !above && !below;
    end

endmodule

// File: tb/tb_agc_controller.sv
module tb_agc_controller;
    import agc_pkg::*;

    localparam real HI_DB = -9.0;
    localparam real LO_DB = -15.0;
    localparam int  NSET  = 4;
    localparam int  NAVG  = 8;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              enable_i = 1'b0;
    logic [RSSI_W-1:0] rssi_dBFS_i = '0;
    logic              rssi_valid_i = 1'b0;
    logic [GAIN_W-1:0] gain_o;
    logic              gain_changed_o;
    logic              locked_o;
`ifdef AGC_MANUAL_OVERRIDE_EN
    logic              manual_en_i = 1'b0;
    logic [GAIN_W-1:0] manual_gain_i = '0;
`endif

    agc_controller dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .enable_i       (enable_i),
        .rssi_dBFS_i    (rssi_dBFS_i),
        .rssi_valid_i   (rssi_valid_i),
`ifdef AGC_MANUAL_OVERRIDE_EN
        .manual_en_i    (manual_en_i),
        .manual_gain_i  (manual_gain_i),
`endif
        .gain_o         (gain_o),
        .gain_changed_o (gain_changed_o),
        .locked_o       (locked_o)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    // Reference model: counts samples in blocks (settle discard, then
    // average) and applies the window rule in real dB.
    int      exp_q[$];
    bit      m_run, m_dec, m_locked;
    int      m_gain, m_settle, m_cnt, ng, e_gain;
    longint  m_sum;
    real     avg_db;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_run = 0; m_dec = 0; m_locked = 0; m_gain = 30;
            m_settle = 0; m_cnt = 0; m_sum = 0;
            exp_q.delete();
        end else if (!enable_i) begin
            m_run = 0; m_dec = 0; m_locked = 0;
        end else if (!m_run) begin
            m_run = 1; m_settle = NSET; m_cnt = 0; m_sum = 0;
        end else if (m_dec) begin
            avg_db = $floor(real'(m_sum) / real'(NAVG)) / 256.0;
            ng = m_gain;
            if (avg_db > HI_DB)      ng = (m_gain - 2 < 0)  ? 0  : m_gain - 2;
            else if (avg_db < LO_DB) ng = (m_gain + 2 > 60) ? 60 : m_gain + 2;
            m_locked = (avg_db <= HI_DB) && (avg_db >= LO_DB);
            if (ng != m_gain) begin
                exp_q.push_back(ng);
                m_settle = NSET;
            end
            m_gain = ng; m_sum = 0; m_cnt = 0; m_dec = 0;
        end else if (rssi_valid_i) begin
            if (m_settle > 0) m_settle--;
            else begin
                m_sum += longint'($signed(rssi_dBFS_i));
                m_cnt++;
                if (m_cnt == NAVG) m_dec = 1;
            end
        end
    end

    // Monitor: a pulse must coincide with a queued expectation.
    always @(negedge clk) begin
        if (rst_n) begin
            if (exp_q.size() > 0) begin
                e_gain = exp_q.pop_front();
                chk("pulse", int'(gain_changed_o), 1);
                chk("pulse_gain", int'(gain_o), e_gain);
            end else begin
                chk("no_pulse", int'(gain_changed_o), 0);
            end
            chk("gain", int'(gain_o), m_gain);
            chk("locked", int'(locked_o), int'(m_locked));
        end
    end

    task automatic cyc(input bit en, input bit v, input int s);
        enable_i     = en;
        rssi_valid_i = v;
        rssi_dBFS_i  = RSSI_W'(s);
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n, input int s);
        for (int i = 0; i < n; i++) cyc(1'b1, 1'b1, s);
    endtask

    localparam int DB_M5  = -1280;
    localparam int DB_M9  = -2304;
    localparam int DB_M12 = -3072;
    localparam int DB_M15 = -3840;
    localparam int DB_M25 = -6400;

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_gain", int'(gain_o), 30);
        chk("rst_locked", int'(locked_o), 0);
        chk("rst_pulse", int'(gain_changed_o), 0);
        rst_n = 1'b1;
        cyc(1'b0, 1'b1, DB_M5);
        cyc(1'b0, 1'b1, DB_M5);
        chk("idle_hold", int'(gain_o), 30);

        // Idle cycle + 4 settle + 8 averaged + decide.
        run(14, DB_M5);
        chk("hot_gain", int'(gain_o), 28);
        chk("hot_locked", int'(locked_o), 0);
        cyc(1'b0, 1'b0, 0);

        // Exact window bounds are in-window.
        run(14, DB_M9);
        chk("bound_hi_gain", int'(gain_o), 28);
        chk("bound_hi_locked", int'(locked_o), 1);
        run(9, DB_M15);
        chk("bound_lo_gain", int'(gain_o), 28);
        chk("bound_lo_locked", int'(locked_o), 1);
        cyc(1'b0, 1'b0, 0);

        // Weak signal climbs to the clamp and stays there silently.
        run(420, DB_M25);
        chk("clamp_gain", int'(gain_o), 60);

        // Partial block abandoned; fresh in-window average must not move gain.
        cyc(1'b0, 1'b0, 0);
        run(10, DB_M5);
        cyc(1'b0, 1'b1, DB_M5);
        cyc(1'b0, 1'b1, DB_M5);
        chk("drop_gain", int'(gain_o), 60);
        chk("drop_locked", int'(locked_o), 0);
        run(14, DB_M12);
        chk("restart_gain", int'(gain_o), 60);
        chk("restart_locked", int'(locked_o), 1);

        // Walk down to 40, then reset asynchronously mid-accumulation.
        for (int i = 0; i < 400 && m_gain != 40; i++) cyc(1'b1, 1'b1, DB_M5);
        chk("reach40", int'(gain_o), 40);
        run(7, DB_M5);
        #3 rst_n = 1'b0;
        #1;
        chk("arst_gain", int'(gain_o), 30);
        chk("arst_locked", int'(locked_o), 0);
        enable_i = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        cyc(1'b0, 1'b1, DB_M25);
        chk("post_rst_gain", int'(gain_o), 30);

        // Random traffic, levels between -40 and +10 dB, sparse valid,
        // occasional enable drops.
        for (int i = 0; i < 3000; i++) begin
            int s;
            case ($urandom_range(0, 5))
                0:       s = DB_M9;
                1:       s = DB_M15;
                default: s = int'($urandom_range(0, 12800)) - 10240;
            endcase
            cyc($urandom_range(0, 99) != 0, $urandom_range(0, 3) != 0, s);
        end
        cyc(1'b0, 1'b0, 0);
        cyc(1'b0, 1'b0, 0);
        chk("queue_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
